// File: rtl/fifo_tx_arbiter.sv
// fifo_tx_arbiter: round-robin drain of two read-side FIFOs into one UART TX via start/busy handshake
module fifo_tx_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 16,
    parameter int TIMEOUT   = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              ch0_rdfull,
    input  logic              ch0_rdempty,
    input  logic [DATA_W-1:0] ch0_q,
    output logic              ch0_rdreq,
    input  logic              ch1_rdfull,
    input  logic              ch1_rdempty,
    input  logic [DATA_W-1:0] ch1_q,
    output logic              ch1_rdreq,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic [1:0]        grant,
    output logic              active
);
    localparam logic [15:0] TMO  = 16'(TIMEOUT);
    localparam logic [7:0]  BMAX = 8'(BURST_MAX);
    typedef enum logic [2:0] {IDLE, READ, CAPT, START, ACK, DONE} state_t;
    state_t              state_q;
    logic [15:0]         age0_q, age1_q, age0_d, age1_d;
    logic [7:0]          burst_q;
    logic [1:0]          grant_q, pick;
    logic                last1_q, ch0_rdreq_q, ch1_rdreq_q, tx_start_q, active_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                el0, el1, more;
    always_comb begin
        age0_d = (ch0_rdempty || grant_q[0]) ? 16'd0 : (age0_q == TMO) ? age0_q : age0_q + 16'd1;
        age1_d = (ch1_rdempty || grant_q[1]) ? 16'd0 : (age1_q == TMO) ? age1_q : age1_q + 16'd1;
        el0    = !ch0_rdempty && (ch0_rdfull || age0_q == TMO);
        el1    = !ch1_rdempty && (ch1_rdfull || age1_q == TMO);
        pick   = (el0 && el1) ? (last1_q ? 2'b01 : 2'b10) : el0 ? 2'b01 : 2'b10;
        more   = (burst_q < BMAX) && enable && !(grant_q[0] ? ch0_rdempty : ch1_rdempty);
    end
    // empty is re-sampled right before every read, so rdreq never hits an empty FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            age0_q      <= '0;
            age1_q      <= '0;
            burst_q     <= '0;
            grant_q     <= '0;
            last1_q     <= 1'b1;
            ch0_rdreq_q <= 1'b0;
            ch1_rdreq_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            active_q    <= 1'b0;
        end else begin
            age0_q      <= age0_d;
            age1_q      <= age1_d;
            tx_start_q  <= 1'b0;
            ch0_rdreq_q <= 1'b0;
            ch1_rdreq_q <= 1'b0;
            case (state_q)
                IDLE: if (enable && (el0 || el1)) begin
                    grant_q     <= pick;
                    burst_q     <= '0;
                    ch0_rdreq_q <= pick[0];
                    ch1_rdreq_q <= pick[1];
                    active_q    <= 1'b1;
                    state_q     <= READ;
                end
                READ: state_q <= CAPT;
                CAPT: begin
                    tx_data_q <= grant_q[0] ? ch0_q : ch1_q;
                    state_q   <= START;
                end
                START: if (!tx_busy) begin
                    tx_start_q <= 1'b1;
                    burst_q    <= burst_q + 8'd1;
                    state_q    <= ACK;
                end
                ACK: if (tx_busy) state_q <= DONE;
                DONE: if (!tx_busy) begin
                    if (more) begin
                        ch0_rdreq_q <= grant_q[0];
                        ch1_rdreq_q <= grant_q[1];
                        state_q     <= READ;
                    end else begin
                        last1_q  <= grant_q[1];
                        grant_q  <= '0;
                        active_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ch0_rdreq = ch0_rdreq_q;
    assign ch1_rdreq = ch1_rdreq_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign grant     = grant_q;
    assign active    = active_q;
endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// tb_fifo_tx_arbiter: directed bench with FIFO and UART models around fifo_tx_arbiter
module tb_fifo_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       full0 = 1'b0, full1 = 1'b0, busy_force = 1'b0;
    logic [7:0] ch0_q = '0, ch1_q = '0;
    logic       ch0_rdempty, ch1_rdempty, ch0_rdreq, ch1_rdreq, tx_busy, tx_start, active;
    logic [7:0] tx_data;
    logic [1:0] grant;
    logic [7:0] mem0 [0:255];
    logic [7:0] mem1 [0:255];
    logic [7:0] log_d [0:255];
    logic [1:0] log_c [0:255];
    int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    int nrd0 = 0, nrd1 = 0, nlog = 0, bcnt = 0, viol_rd = 0, viol_tx = 0;
    int checks = 0, errors = 0;
    int base, brd0, brd1;
    always #5 clk = ~clk;
    assign ch0_rdempty = (rd0 == wr0);
    assign ch1_rdempty = (rd1 == wr1);
    assign tx_busy     = (bcnt != 0) || busy_force;
    fifo_tx_arbiter dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .ch0_rdfull(full0), .ch0_rdempty(ch0_rdempty), .ch0_q(ch0_q), .ch0_rdreq(ch0_rdreq),
        .ch1_rdfull(full1), .ch1_rdempty(ch1_rdempty), .ch1_q(ch1_q), .ch1_rdreq(ch1_rdreq),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .grant(grant), .active(active)
    );
    // FIFO read ports (1-cycle latency) and a UART that goes busy for 20 cycles after each start
    always @(posedge clk) begin
        if (ch0_rdreq) begin
            if (rd0 == wr0) viol_rd <= viol_rd + 1;
            ch0_q <= mem0[rd0];
            rd0   <= rd0 + 1;
            nrd0  <= nrd0 + 1;
        end
        if (ch1_rdreq) begin
            if (rd1 == wr1) viol_rd <= viol_rd + 1;
            ch1_q <= mem1[rd1];
            rd1   <= rd1 + 1;
            nrd1  <= nrd1 + 1;
        end
        if (tx_start) begin
            if (tx_busy) viol_tx <= viol_tx + 1;
            log_d[nlog] <= tx_data;
            log_c[nlog] <= grant;
            nlog        <= nlog + 1;
            bcnt        <= 20;
        end else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        int segs [6] = '{16, 16, 16, 16, 8, 8};
        int idx, n0, n1;
        repeat (3) @(negedge clk);
        chk("rst_rdreq0", ch0_rdreq, 0);
        chk("rst_rdreq1", ch1_rdreq, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_active", active, 0);
        rst_n = 1'b1;
        // basic 3-byte drain of ch0
        base = nlog; brd0 = nrd0;
        mem0[wr0] = 8'h41; mem0[wr0+1] = 8'h42; mem0[wr0+2] = 8'h43; wr0 += 3;
        full0 = 1'b1;
        for (int i = 0; i < 10 && grant == 2'b00; i++) @(negedge clk);
        chk("t1_grant", grant, 2'b01);
        for (int i = 0; i < 400 && !(nlog - base == 3 && !active); i++) @(negedge clk);
        chk("t1_rdreqs", nrd0 - brd0, 3);
        chk("t1_starts", nlog - base, 3);
        chk("t1_b0", log_d[base], 8'h41);
        chk("t1_b1", log_d[base+1], 8'h42);
        chk("t1_b2", log_d[base+2], 8'h43);
        chk("t1_idle", active, 0);
        chk("t1_grant0", grant, 0);
        full0 = 1'b0;
        // fresh reset so ch0 wins the first tie, then two full channels of 40 bytes
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = nlog;
        for (int i = 0; i < 40; i++) begin
            mem0[wr0+i] = 8'(i);
            mem1[wr1+i] = 8'(8'h80 + i);
        end
        wr0 += 40; wr1 += 40;
        full0 = 1'b1; full1 = 1'b1;
        for (int i = 0; i < 5000 && !(nlog - base == 80 && !active); i++) @(negedge clk);
        chk("t2_count", nlog - base, 80);
        idx = 0; n0 = 0; n1 = 0;
        for (int s = 0; s < 6; s++)
            for (int k = 0; k < segs[s]; k++) begin
                chk("t2_ch", log_c[base+idx], (s % 2) ? 2 : 1);
                chk("t2_data", log_d[base+idx], (s % 2) ? 8'h80 + n1 : n0);
                if (s % 2) n1++; else n0++;
                idx++;
            end
        full0 = 1'b0; full1 = 1'b0;
        // timeout eligibility of a lone non-full byte on ch1
        base = nlog;
        @(negedge clk);
        mem1[wr1] = 8'h5A; wr1 += 1;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("t3_nogrant", grant, 0);
        chk("t3_age", dut.age1_q, 1000);
        @(negedge clk);
        chk("t3_grant", grant, 2'b10);
        for (int i = 0; i < 100 && !(nlog - base == 1 && !active); i++) @(negedge clk);
        chk("t3_count", nlog - base, 1);
        chk("t3_data", log_d[base], 8'h5A);
        chk("t3_age0", dut.age1_q, 0);
        // busy held high across START, then across ACK
        base = nlog; brd0 = nrd0;
        busy_force = 1'b1;
        mem0[wr0] = 8'h77; wr0 += 1;
        full0 = 1'b1;
        repeat (30) @(negedge clk);
        chk("t4_rd", nrd0 - brd0, 1);
        chk("t4_nostart", nlog - base, 0);
        busy_force = 1'b0;
        for (int i = 0; i < 10 && !tx_start; i++) @(negedge clk);
        chk("t4_pulse", tx_start, 1);
        chk("t4_data", tx_data, 8'h77);
        @(negedge clk);
        chk("t4_pulse_end", tx_start, 0);
        busy_force = 1'b1;
        repeat (40) @(negedge clk);
        chk("t4_single", nlog - base, 1);
        busy_force = 1'b0;
        for (int i = 0; i < 50 && active; i++) @(negedge clk);
        chk("t4_idle", active, 0);
        full0 = 1'b0;
        // enable dropped during the third byte of a 10-byte burst
        base = nlog; brd0 = nrd0;
        for (int i = 0; i < 10; i++) mem0[wr0+i] = 8'(8'hA0 + i);
        wr0 += 10;
        full0 = 1'b1;
        for (int i = 0; i < 400 && nlog - base != 3; i++) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 100 && active; i++) @(negedge clk);
        chk("t5_idle", active, 0);
        chk("t5_rd", nrd0 - brd0, 3);
        chk("t5_starts", nlog - base, 3);
        repeat (50) @(negedge clk);
        chk("t5_rd_hold", nrd0 - brd0, 3);
        chk("t5_grant", grant, 0);
        chk("t5_b2", log_d[base+2], 8'hA2);
        // reset asserted while in ACK
        base = nlog;
        enable = 1'b1;
        for (int i = 0; i < 100 && !tx_start; i++) @(negedge clk);
        chk("t6_in_ack", tx_start, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async", {ch0_rdreq, ch1_rdreq, tx_start, tx_data, grant, active}, 0);
        mem1[wr1] = 8'hB0; mem1[wr1+1] = 8'hB1; wr1 += 2;
        full1 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        base = nlog; brd1 = nrd1;
        chk("t6_norq", {ch0_rdreq, ch1_rdreq}, 0);
        for (int i = 0; i < 10 && grant == 2'b00; i++) @(negedge clk);
        chk("t6_grant", grant, 2'b01);
        for (int i = 0; i < 800 && !(nlog - base == 8 && !active); i++) @(negedge clk);
        chk("t6_count", nlog - base, 8);
        chk("t6_first", log_d[base], 8'hA4);
        chk("t6_last0", log_d[base+5], 8'hA9);
        chk("t6_ch1", log_c[base+6], 2'b10);
        chk("t6_ch1_data", log_d[base+7], 8'hB1);
        chk("t6_rd1", nrd1 - brd1, 2);
        chk("no_empty_reads", viol_rd, 0);
        chk("no_start_busy", viol_tx, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
